inst_sram_resp: RTL and testbench

- Responder end of the instruction-SRAM interface.
- Answers the fetch stage's en/wen/addr/wdata requests with rdata one cycle later, backed by an internal word array.
- Byte-lane writes are supported, so the bench or a debug loader can patch the image.
- A power-up scrub FSM fills memory with a known word; `init_done` is exported so the top level holds the CPU in reset until the scrub completes.

---
 rtl/inst_sram_pkg.sv | 33 +++
 rtl/inst_sram_resp_if.sv | 11 +
 rtl/sram_scrub_fsm.sv | 55 +++++
 rtl/inst_sram_resp.sv | 147 ++++++++++++++
 tb/tb_inst_sram_resp.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_sram_pkg.sv
// Shared types and helpers for the instruction-SRAM responder: FSM state,
// default memory-map constants and the address decoder.
package inst_sram_pkg;

    typedef enum logic [0:0] {StInit, StReady} state_t;

    localparam logic [31:0] DefaultBaseAddr = 32'h1c00_0000;
    localparam logic [31:0] DefaultFillWord = 32'h0000_0000;

    typedef struct packed {
        logic        hit;
        logic [29:0] word;
    } decode_t;

    // Word offset from the window base, modulo 2^30. Addresses below the base
    // wrap to a huge offset and so miss. Byte-offset bits of addr are ignored.
    function automatic decode_t decode_addr(logic [31:0] addr, logic [31:0] base,
                                            int unsigned addr_w);
        decode_t d;
        d.word = addr[31:2] - base[31:2];
        d.hit  = (d.word >> addr_w) == 30'd0;
        return d;
    endfunction

    function automatic logic [3:0] lane_parity(logic [31:0] w);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/inst_sram_resp_if.sv
// Fetch-side instruction-SRAM request/response bus.
interface inst_sram_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_scrub_fsm.sv
// Power-up scrub sequencer: walks every word index once after reset, then
// parks in READY with init_done high until the next reset.
module sram_scrub_fsm
    import inst_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    output logic              scrub_we,
    output logic [ADDR_W-1:0] scrub_idx
);

    localparam logic [ADDR_W-1:0] LastIdx = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        scrub_we = 1'b0;
        case (state_q)
            StInit: begin
                scrub_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                // The last word is written on the same edge that enters READY.
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    assign init_done = (state_q == StReady);
    assign scrub_idx = cnt_q;

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: registered 1-cycle reads, byte-lane writes and a
// power-up scrub. Define INST_SRAM_PARITY_EN for per-lane parity checking.
module inst_sram_resp
    import inst_sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
    parameter logic [31:0] FILL_WORD = DefaultFillWord
) (
    input  logic             clk,
    input  logic             reset,
    inst_sram_resp_if.slave  bus,
    output logic             init_done,
    output logic             addr_err
`ifdef INST_SRAM_PARITY_EN
    ,
    input  logic [3:0]       inj_par_flip,
    output logic             parity_err
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    logic              scrub_we;
    logic [ADDR_W-1:0] scrub_idx;

    sram_scrub_fsm #(
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .clk       (clk),
        .reset     (reset),
        .init_done (init_done),
        .scrub_we  (scrub_we),
        .scrub_idx (scrub_idx)
    );

    decode_t           dec;
    logic [ADDR_W-1:0] req_idx;
    logic              req_act;
    logic              req_rd;
    logic              req_wr;
    logic              unused_word_hi;
    logic              unused_addr_lsb;

    assign dec             = decode_addr(bus.addr, BASE_ADDR, ADDR_W);
    assign req_idx         = dec.word[ADDR_W-1:0];
    assign unused_word_hi  = ^dec.word[29:ADDR_W];
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Requests are only honoured once the scrub has finished.
    assign req_act = init_done & bus.en;
    assign req_rd  = req_act & dec.hit & (bus.wen == 4'h0);
    assign req_wr  = req_act & dec.hit & (bus.wen != 4'h0);

    // Array write port: the scrub owns it during INIT, requests afterwards.
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_wdata;

    always_comb begin
        mem_be    = 4'h0;
        mem_idx   = req_idx;
        mem_wdata = bus.wdata;
        if (scrub_we) begin
            mem_be    = 4'hf;
            mem_idx   = scrub_idx;
            mem_wdata = FILL_WORD;
        end else if (req_wr) begin
            mem_be = bus.wen;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) begin
                mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    logic [31:0] rd_word;
    assign rd_word = mem[req_idx];

    logic [31:0] rdata_q, rdata_d;
    logic        addr_err_q, addr_err_d;

    always_comb begin
        rdata_d    = rdata_q;
        addr_err_d = addr_err_q;
        if (req_act) begin
            if (!dec.hit) begin
                addr_err_d = 1'b1;
                if (bus.wen == 4'h0) begin
                    rdata_d = 32'h0;
                end
            end else if (req_rd) begin
                rdata_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign addr_err  = addr_err_q;

`ifdef INST_SRAM_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic [3:0] par_wdata;
    logic       par_bad;
    logic       parity_err_q;

    // Injection only applies to request writes, never to the scrub pattern.
    assign par_wdata = lane_parity(mem_wdata) ^ (scrub_we ? 4'h0 : inj_par_flip);

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) begin
                par_mem[mem_idx][i] <= par_wdata[i];
            end
        end
    end

    assign par_bad = req_rd & (|(lane_parity(rd_word) ^ par_mem[req_idx]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else if (par_bad) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_inst_sram_resp.sv
// Scoreboard bench for inst_sram_resp: expected rdata is queued when a request
// is driven and popped when the DUT's registered response is sampled.
module tb_inst_sram_resp;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h1c00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_done;
    logic addr_err;
`ifdef INST_SRAM_PARITY_EN
    logic [3:0] inj_par_flip = 4'h0;
    logic       parity_err;
`endif

    inst_sram_resp_if bus ();

    inst_sram_resp #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .FILL_WORD (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .init_done (init_done),
        .addr_err  (addr_err)
`ifdef INST_SRAM_PARITY_EN
        ,
        .inj_par_flip (inj_par_flip),
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] model[int];
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input int idx);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    // One request cycle: drive at negedge, predict, sample 1 time unit past the edge.
    task automatic req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
        logic [31:0] off;
        logic [31:0] w;
        logic        hit;
        int          idx;
        @(negedge clk);
        bus.en    = en;
        bus.wen   = wen;
        bus.addr  = addr;
        bus.wdata = wdata;
        off = addr - BASE;
        hit = off < 4 * DEPTH;
        idx = int'(off >> 2);
        if (en) begin
            if (!hit) begin
                exp_err = 1'b1;
                if (wen == 4'h0) exp_rdata = 32'h0;
            end else if (wen == 4'h0) begin
                exp_rdata = model_rd(idx);
            end else begin
                w = model_rd(idx);
                for (int i = 0; i < 4; i++) begin
                    if (wen[i]) w[8*i +: 8] = wdata[8*i +: 8];
                end
                model[idx] = w;
            end
        end
        sb_q.push_back(exp_rdata);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        check_eq({tag, "_rdata"}, bus.rdata, sb_q.pop_front());
        check_eq({tag, "_aerr"}, {31'b0, addr_err}, {31'b0, exp_err});
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        for (int i = 0; i < DEPTH + 16; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (init_done) break;
        end
    endtask

    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;

    initial begin
        bus.en    = 1'b0;
        bus.wen   = 4'h0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_init_done", {31'b0, init_done}, 32'h0);
        check_eq("rst_addr_err", {31'b0, addr_err}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        wait_init(cyc);
        check_eq("scrub_cycles", cyc, DEPTH);

        req(1'b1, 4'h0, BASE, 32'h0, "rd_base_fill");
        req(1'b1, 4'hf, BASE + 32'h10, 32'h1234_5678, "wr_full");
        req(1'b1, 4'h0, BASE + 32'h10, 32'h0, "rd_full");
        check_eq("full_literal", bus.rdata, 32'h1234_5678);
        req(1'b1, 4'b0101, BASE + 32'h10, 32'hAABB_CCDD, "wr_lane");
        req(1'b1, 4'h0, BASE + 32'h10, 32'h0, "rd_lane");
        check_eq("lane_literal", bus.rdata, 32'h12BB_56DD);

        // Idle cycles with write-looking side signals must neither move rdata nor write.
        req(1'b1, 4'h0, BASE + 32'h10, 32'h0, "rd_hold");
        repeat (5) req(1'b0, 4'hf, BASE + 32'h10, 32'hDEAD_BEEF, "idle");
        req(1'b1, 4'h0, BASE + 32'h13, 32'h0, "rd_unaligned");

        req(1'b1, 4'hf, BASE + 4 * DEPTH - 4, 32'hCAFE_F00D, "wr_top");
        req(1'b1, 4'h0, BASE + 4 * DEPTH - 4, 32'h0, "rd_top");
        req(1'b1, 4'hf, BASE, 32'hA5A5_A5A5, "wr_base");
        req(1'b1, 4'h0, BASE + 32'h10, 32'h0, "rd_pre_oor");
        req(1'b1, 4'h0, BASE - 4, 32'h0, "rd_below");
        req(1'b1, 4'hf, BASE + 4 * DEPTH, 32'h5A5A_5A5A, "wr_above");
        req(1'b1, 4'h0, BASE, 32'h0, "rd_base_kept");

        for (int i = 0; i < 16; i++) begin
            a  = BASE + ($urandom_range(0, DEPTH - 1) << 2);
            d  = $urandom;
            be = 4'($urandom_range(1, 15));
            req(1'b1, be, a, d, "rnd_wr");
            req(1'b1, 4'h0, a, 32'h0, "rnd_rd");
        end

        // Asynchronous reset mid-cycle must clear the outputs immediately.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_rdata", bus.rdata, 32'h0);
        check_eq("async_addr_err", {31'b0, addr_err}, 32'h0);
        check_eq("async_init_done", {31'b0, init_done}, 32'h0);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        model.delete();

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.en    = 1'b1;
            bus.wen   = 4'h0;
            bus.addr  = (i % 2 == 0) ? BASE + 32'h10 : BASE - 4;
            bus.wdata = 32'h0;
        end
        @(posedge clk);
        #1;
        check_eq("init_ignore_rdata", bus.rdata, 32'h0);
        check_eq("init_ignore_aerr", {31'b0, addr_err}, 32'h0);
        check_eq("init_not_done", {31'b0, init_done}, 32'h0);
        bus.en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_eq("midscrub_init_done", {31'b0, init_done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_init(cyc);
        check_eq("rescrub_cycles", cyc, DEPTH);
        req(1'b1, 4'h0, BASE + 32'h10, 32'h0, "rd_rescrubbed");

`ifdef INST_SRAM_PARITY_EN
        req(1'b1, 4'hf, BASE + 32'h20, 32'h0F0F_1234, "par_wr_clean");
        req(1'b1, 4'h0, BASE + 32'h20, 32'h0, "par_rd_clean");
        check_eq("par_clean", {31'b0, parity_err}, 32'h0);
        inj_par_flip = 4'b0001;
        req(1'b1, 4'hf, BASE + 32'h24, 32'h1357_9BDF, "par_wr_inj");
        inj_par_flip = 4'b0000;
        check_eq("par_after_wr", {31'b0, parity_err}, 32'h0);
        req(1'b1, 4'h0, BASE + 32'h24, 32'h0, "par_rd_inj");
        check_eq("par_detect", {31'b0, parity_err}, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
